// File: rtl/bootcode_trace_monitor_if.sv
// Trace drain port: valid/ready stream of timestamped boot events.
interface bootcode_trace_monitor_if #(
  parameter int DATA_W = 32,
  parameter int TS_W   = 24
);
  logic              TrcValid;
  logic              TrcReady;
  logic [1:0]        TrcKind;
  logic [2:0]        TrcChan;
  logic [DATA_W-1:0] TrcData;
  logic [TS_W-1:0]   TrcTime;

  modport master (output TrcValid, TrcKind, TrcChan, TrcData, TrcTime, input TrcReady);
  modport slave  (input TrcValid, TrcKind, TrcChan, TrcData, TrcTime, output TrcReady);
endinterface

// File: rtl/bootcode_trace_monitor.sv
// Boot trace monitor: postcode change / error / PC-hang detection feeding a
// timestamped first-word-fall-through trace FIFO.
module bootcode_trace_monitor #(
  parameter int         NUM_CH       = 4,
  parameter int         POST_WIDTH   = 32,
  parameter int         PC_WIDTH     = 32,
  parameter int         DEPTH        = 16,
  parameter int         TS_WIDTH     = 24,
  parameter logic [7:0] ERR_CODE_MIN = 8'hF0,
  parameter int         HANG_CYCLES  = 1024
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         Enable,
  input  logic [NUM_CH*POST_WIDTH-1:0] PostCode,
  input  logic [NUM_CH-1:0]            PostValid,
  input  logic [PC_WIDTH-1:0]          PC,
  input  logic                         PcValid,
  bootcode_trace_monitor_if.master     trc,
  output logic                         ErrSticky,
  output logic [2:0]                   ErrChan,
  output logic                         Hang,
  output logic [15:0]                  DropCnt,
  input  logic                         ClearErr
);
  localparam int DW = (POST_WIDTH > PC_WIDTH) ? POST_WIDTH : PC_WIDTH;
  localparam int EW = 5 + DW + TS_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HANG_CYCLES + 1);

  logic [TS_WIDTH-1:0] r_ts_cnt;
  logic [NUM_CH-1:0]   w_evt, w_err, w_ovr, w_pend_vld, w_sel_ch;
  logic [EW-1:0]       w_pend_ent [NUM_CH];
  logic                w_sel_valid, w_push, w_pop, w_full;
  logic                w_to_out, w_to_mem, w_mem_rd;
  logic [EW-1:0]       w_sel_ent;
  logic [3:0]          w_drops;
  logic [16:0]         w_drop_sum;
  logic [2:0]          w_err_ch;

  logic [PC_WIDTH-1:0] r_last_pc;
  logic                r_pc_seen, r_hang, r_hang_pend, w_pc_chg;
  logic [HW-1:0]       r_hang_cnt;
  logic [EW-1:0]       r_hang_ent;

  logic [EW-1:0]       r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [AW:0]         r_mem_cnt;
  logic                r_out_vld;
  logic [EW-1:0]       r_out_ent;

  logic                r_err_sticky;
  logic [2:0]          r_err_chan;
  logic [15:0]         r_drop_cnt;

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) r_ts_cnt <= '0;
    else          r_ts_cnt <= r_ts_cnt + TS_WIDTH'(1);

  // LastPost tracks every valid sample, even while capture is disabled
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [POST_WIDTH-1:0] w_code;
    logic [1:0]            w_kind;
    logic [POST_WIDTH-1:0] r_last_post;
    logic                  r_last_vld;
    logic                  r_pend_vld;
    logic [EW-1:0]         r_pend_ent;

    assign w_code         = PostCode[gi*POST_WIDTH +: POST_WIDTH];
    assign w_kind         = (w_code[POST_WIDTH-1 -: 8] >= ERR_CODE_MIN) ? 2'd1 : 2'd0;
    assign w_evt[gi]      = Enable & PostValid[gi] & (~r_last_vld | (w_code != r_last_post));
    assign w_err[gi]      = w_evt[gi] & w_kind[0];
    assign w_ovr[gi]      = w_evt[gi] & r_pend_vld & ~w_sel_ch[gi];
    assign w_pend_vld[gi] = r_pend_vld;
    assign w_pend_ent[gi] = r_pend_ent;

    always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
        r_last_post <= '0;
        r_last_vld  <= 1'b0;
        r_pend_vld  <= 1'b0;
        r_pend_ent  <= '0;
      end else begin
        if (PostValid[gi]) begin
          r_last_post <= w_code;
          r_last_vld  <= 1'b1;
        end
        if (w_evt[gi]) begin
          r_pend_vld <= 1'b1;
          r_pend_ent <= {w_kind, 3'(gi), DW'(w_code), r_ts_cnt};
        end else if (w_sel_ch[gi]) begin
          r_pend_vld <= 1'b0;
        end
      end
  end

  // Hang pending wins, then the lowest-index pending channel
  always_comb begin
    w_sel_valid = r_hang_pend;
    w_sel_ent   = r_hang_ent;
    w_sel_ch    = '0;
    if (!r_hang_pend) begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (w_pend_vld[c]) begin
          w_sel_valid = 1'b1;
          w_sel_ent   = w_pend_ent[c];
          w_sel_ch    = '0;
          w_sel_ch[c] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_err_ch = '0;
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (w_err[c]) w_err_ch = 3'(c);
  end

  assign w_pop    = r_out_vld & trc.TrcReady;
  assign w_full   = r_out_vld & (r_mem_cnt == (AW+1)'(DEPTH - 1));
  assign w_push   = w_sel_valid & (~w_full | w_pop);
  assign w_to_out = w_push & (~r_out_vld | (w_pop & (r_mem_cnt == '0)));
  assign w_to_mem = w_push & ~w_to_out;
  assign w_mem_rd = w_pop & (r_mem_cnt != '0);

  always_comb begin
    w_drops = {3'd0, w_sel_valid & ~w_push};
    for (int c = 0; c < NUM_CH; c++) w_drops = w_drops + {3'd0, w_ovr[c]};
  end
  assign w_drop_sum = {1'b0, (ClearErr ? 16'd0 : r_drop_cnt)} + 17'(w_drops);

  assign w_pc_chg = PcValid & (~r_pc_seen | (PC != r_last_pc));

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      r_last_pc   <= '0;
      r_pc_seen   <= 1'b0;
      r_hang_cnt  <= '0;
      r_hang      <= 1'b0;
      r_hang_pend <= 1'b0;
      r_hang_ent  <= '0;
    end else begin
      if (PcValid) begin
        r_last_pc <= PC;
        r_pc_seen <= 1'b1;
      end
      if (w_pc_chg || !Enable || !PcValid) r_hang_cnt <= '0;
      else if (r_hang_cnt != HW'(HANG_CYCLES)) r_hang_cnt <= r_hang_cnt + HW'(1);
      if (r_hang_pend) r_hang_pend <= 1'b0;
      if (w_pc_chg) begin
        r_hang <= 1'b0;
      end else if (Enable && !r_hang && r_hang_cnt == HW'(HANG_CYCLES)) begin
        r_hang      <= 1'b1;
        r_hang_pend <= 1'b1;
        r_hang_ent  <= {2'd2, 3'd0, DW'(r_last_pc), r_ts_cnt};
      end
    end

  always_ff @(posedge Clk)
    if (w_to_mem) r_mem[r_wr_ptr] <= w_sel_ent;

  // Output register is the head; the array holds everything behind it
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_mem_cnt <= '0;
      r_out_vld <= 1'b0;
      r_out_ent <= '0;
    end else begin
      if (w_to_mem) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_mem_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_mem_cnt <= r_mem_cnt + (AW+1)'(w_to_mem) - (AW+1)'(w_mem_rd);
      if (w_mem_rd) begin
        r_out_ent <= r_mem[r_rd_ptr];
        r_out_vld <= 1'b1;
      end else if (w_to_out) begin
        r_out_ent <= w_sel_ent;
        r_out_vld <= 1'b1;
      end else if (w_pop) begin
        r_out_vld <= 1'b0;
      end
    end

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      r_err_sticky <= 1'b0;
      r_err_chan   <= '0;
      r_drop_cnt   <= '0;
    end else begin
      if (|w_err) begin
        r_err_sticky <= 1'b1;
        if (!r_err_sticky || ClearErr) r_err_chan <= w_err_ch;
      end else if (ClearErr) begin
        r_err_sticky <= 1'b0;
        r_err_chan   <= '0;
      end
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

  assign trc.TrcValid = r_out_vld;
  assign {trc.TrcKind, trc.TrcChan, trc.TrcData, trc.TrcTime} = r_out_ent;
  assign ErrSticky = r_err_sticky;
  assign ErrChan   = r_err_chan;
  assign Hang      = r_hang;
  assign DropCnt   = r_drop_cnt;
endmodule
